// File: rtl/reg_wr_arb_pkg.sv
// rtl/reg_wr_arb_pkg.sv - shared types and default widths for the register write arbiter
package reg_wr_arb_pkg;

    localparam int N_DEF  = 4;
    localparam int CW_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WR   = 2'b01,
        ST_ACK  = 2'b10
    } state_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/reg_wr_arb_ldreg.sv
// rtl/reg_wr_arb_ldreg.sv - load-enabled n-bit register clocked on the falling edge
module reg_wr_arb_ldreg #(
    parameter int W = 4
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(negedge ck or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin picker
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] win,
    output logic       valid
);

    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = ptr ? 2'b10 : 2'b01;
            default: win = 2'b00;
        endcase
    end

    assign valid = |req;

endmodule

// File: rtl/reg_wr_arb.sv
// rtl/reg_wr_arb.sv - two-requester round-robin write sequencer for a shared register
// Optional grant locking is built when REG_WR_ARB_LOCK_EN is defined.
module reg_wr_arb
    import reg_wr_arb_pkg::*;
#(
    parameter int n  = N_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          req0,
    input  logic [n-1:0]  d0,
    input  logic          req1,
    input  logic [n-1:0]  d1,
`ifdef REG_WR_ARB_LOCK_EN
    input  logic          lock0,
    input  logic          lock1,
`endif
    output logic          ack0,
    output logic          ack1,
    output logic [1:0]    gnt,
    output logic          busy,
    output logic [n-1:0]  q,
    output logic [CW-1:0] wcnt
);

    state_t        r_state;
    logic          r_win;
    logic          r_ptr;
    logic [1:0]    r_gnt;
    logic [1:0]    r_ack;
    logic          r_busy;
    logic [CW-1:0] r_wcnt;

    logic [1:0]    w_win;
    logic          w_valid;
    logic          w_load;
    logic [n-1:0]  w_data;
    logic          w_keep;

    rr_pick2 u_pick (
        .req   ({req1, req0}),
        .ptr   (r_ptr),
        .win   (w_win),
        .valid (w_valid)
    );

    // Winner's data is taken live during WR; requesters hold it stable until ack.
    assign w_load = (r_state == ST_WR);
    assign w_data = r_win ? d1 : d0;

`ifdef REG_WR_ARB_LOCK_EN
    assign w_keep = r_win ? lock1 : lock0;
`else
    assign w_keep = 1'b0;
`endif

    always_ff @(negedge ck or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_win   <= 1'b0;
            r_ptr   <= 1'b0;
            r_gnt   <= 2'b00;
            r_ack   <= 2'b00;
            r_busy  <= 1'b0;
            r_wcnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_win   <= w_win[1];
                        r_gnt   <= w_win;
                        r_busy  <= 1'b1;
                        r_state <= ST_WR;
                    end
                end
                ST_WR: begin
                    r_gnt   <= 2'b00;
                    r_ack   <= onehot2(r_win);
                    r_wcnt  <= r_wcnt + CW'(1);
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    r_ack   <= 2'b00;
                    r_busy  <= 1'b0;
                    r_ptr   <= w_keep ? r_win : ~r_win;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_gnt   <= 2'b00;
                    r_ack   <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    reg_wr_arb_ldreg #(.W(n)) u_reg (
        .ck  (ck),
        .rst (rst),
        .ld  (w_load),
        .d   (w_data),
        .q   (q)
    );

    assign gnt  = r_gnt;
    assign ack0 = r_ack[0];
    assign ack1 = r_ack[1];
    assign busy = r_busy;
    assign wcnt = r_wcnt;

endmodule

// File: tb/tb_reg_wr_arb.sv
// tb/tb_reg_wr_arb.sv - self-checking bench for reg_wr_arb with a transaction-level reference model
module tb_reg_wr_arb;

    logic       ck   = 1'b0;
    logic       rst  = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [3:0] d0   = 4'h0;
    logic [3:0] d1   = 4'h0;
`ifdef REG_WR_ARB_LOCK_EN
    logic       lock0 = 1'b0;
    logic       lock1 = 1'b0;
`endif
    logic       ack0, ack1, busy;
    logic [1:0] gnt;
    logic [3:0] q, wcnt;
    logic [12:0] obs;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 ck = ~ck;

    assign obs = {gnt, ack1, ack0, busy, q, wcnt};

    reg_wr_arb #(.n(4), .CW(4)) dut (
        .ck    (ck),
        .rst   (rst),
        .req0  (req0),
        .d0    (d0),
        .req1  (req1),
        .d1    (d1),
`ifdef REG_WR_ARB_LOCK_EN
        .lock0 (lock0),
        .lock1 (lock1),
`endif
        .ack0  (ack0),
        .ack1  (ack1),
        .gnt   (gnt),
        .busy  (busy),
        .q     (q),
        .wcnt  (wcnt)
    );

    task automatic do_reset;
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge ck);
        @(posedge ck);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [12:0] exp;
        @(posedge ck);
        #1;
        exp = 13'h0;
        chk_cnt++;
        if (obs !== exp) $display("FAIL reset_por: got %h expected %h", obs, exp);
        else pass_cnt++;
        @(posedge ck);
        rst = 1'b0;
    endtask

    task automatic test_single;
        logic [12:0] exp;
        req0 = 1'b1;
        d0   = 4'b1010;
        @(posedge ck);
        exp = {2'b01, 3'b001, 4'h0, 4'h0};
        chk_cnt++;
        if (obs !== exp) $display("FAIL single_wr: got %h expected %h", obs, exp);
        else pass_cnt++;
        @(posedge ck);
        exp = {2'b00, 3'b011, 4'b1010, 4'h1};
        chk_cnt++;
        if (obs !== exp) $display("FAIL single_ack: got %h expected %h", obs, exp);
        else pass_cnt++;
        req0 = 1'b0;
        @(posedge ck);
        exp = {2'b00, 3'b000, 4'b1010, 4'h1};
        chk_cnt++;
        if (obs !== exp) $display("FAIL single_idle: got %h expected %h", obs, exp);
        else pass_cnt++;
    endtask

    task automatic test_async_reset;
        logic [12:0] exp;
        #3;
        rst = 1'b1;
        #1;
        exp = 13'h0;
        chk_cnt++;
        if (obs !== exp) $display("FAIL async_reset: got %h expected %h", obs, exp);
        else pass_cnt++;
        @(posedge ck);
        rst = 1'b0;
    endtask

    task automatic test_contention;
        logic [12:0] exp;
        req0 = 1'b1; req1 = 1'b1;
        d0 = 4'b0011; d1 = 4'b1100;
        @(posedge ck);
        exp = {2'b01, 3'b001, 4'h0, 4'h0};
        chk_cnt++;
        if (obs !== exp) $display("FAIL cont_wr0: got %h expected %h", obs, exp);
        else pass_cnt++;
        @(posedge ck);
        exp = {2'b00, 3'b011, 4'b0011, 4'h1};
        chk_cnt++;
        if (obs !== exp) $display("FAIL cont_ack0: got %h expected %h", obs, exp);
        else pass_cnt++;
        req0 = 1'b0;
        @(posedge ck);
        exp = {2'b00, 3'b000, 4'b0011, 4'h1};
        chk_cnt++;
        if (obs !== exp) $display("FAIL cont_idle: got %h expected %h", obs, exp);
        else pass_cnt++;
        @(posedge ck);
        exp = {2'b10, 3'b001, 4'b0011, 4'h1};
        chk_cnt++;
        if (obs !== exp) $display("FAIL cont_wr1: got %h expected %h", obs, exp);
        else pass_cnt++;
        @(posedge ck);
        exp = {2'b00, 3'b101, 4'b1100, 4'h2};
        chk_cnt++;
        if (obs !== exp) $display("FAIL cont_ack1: got %h expected %h", obs, exp);
        else pass_cnt++;
        req1 = 1'b0;
        @(posedge ck);
    endtask

    task automatic test_fairness;
        logic [7:0] order;
        int nacks;
        do_reset;
        order = 8'h0;
        nacks = 0;
        req0 = 1'b1; req1 = 1'b1;
        d0 = 4'($urandom); d1 = 4'($urandom);
        for (int s = 0; s < 12; s++) begin
            @(posedge ck);
            if (ack0 || ack1) begin
                order = {order[5:0], ack1, ack0};
                nacks++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk_cnt++;
        if (nacks != 4) $display("FAIL fair_count: got %0d expected 4", nacks);
        else pass_cnt++;
        chk_cnt++;
        if (order !== 8'b01_10_01_10) $display("FAIL fair_order: got %b expected 01100110", order);
        else pass_cnt++;
        @(posedge ck);
        @(posedge ck);
    endtask

    task automatic test_abort;
        logic [12:0] exp;
        req1 = 1'b1;
        d1   = 4'h9;
        @(posedge ck);
        chk_cnt++;
        if (gnt !== 2'b10) $display("FAIL abort_wr: got gnt %b expected 10", gnt);
        else pass_cnt++;
        #2;
        rst  = 1'b1;
        req1 = 1'b0;
        #1;
        exp = 13'h0;
        chk_cnt++;
        if (obs !== exp) $display("FAIL abort_rst: got %h expected %h", obs, exp);
        else pass_cnt++;
        @(posedge ck);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(posedge ck);
            chk_cnt++;
            if (obs !== exp) $display("FAIL abort_noack: got %h expected %h", obs, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_wrap;
        logic [12:0] exp;
        logic [3:0]  dv;
        for (int i = 0; i < 16; i++) begin
            dv   = 4'($urandom);
            req0 = 1'b1;
            d0   = dv;
            @(posedge ck);
            @(posedge ck);
            exp = {2'b00, 3'b011, dv, 4'(i + 1)};
            chk_cnt++;
            if (obs !== exp) $display("FAIL wrap_ack%0d: got %h expected %h", i, obs, exp);
            else pass_cnt++;
            req0 = 1'b0;
            @(posedge ck);
        end
    endtask

    // Model: a grant seen at step g is acked at g+1; arbitration happens only after idle steps.
    task automatic test_random;
        int          g;
        logic        m_w, m_ptr;
        logic [3:0]  m_q, m_d, m_cnt;
        logic [1:0]  pend;
        logic [3:0]  dat [2];
        logic [12:0] exp;
        do_reset;
        g = -10; m_w = 1'b0; m_ptr = 1'b0;
        m_q = 4'h0; m_d = 4'h0; m_cnt = 4'h0;
        pend = 2'b00; dat[0] = 4'h0; dat[1] = 4'h0;
        for (int s = 0; s < 240; s++) begin
            @(posedge ck);
            if (s == g + 1) begin
                m_q   = m_d;
                m_cnt = m_cnt + 4'd1;
            end
            if (s == g)
                exp = {(m_w ? 2'b10 : 2'b01), 3'b001, m_q, m_cnt};
            else if (s == g + 1)
                exp = {2'b00, m_w, !m_w, 1'b1, m_q, m_cnt};
            else
                exp = {5'b00000, m_q, m_cnt};
            chk_cnt++;
            if (obs !== exp) $display("FAIL rand step %0d: got %h expected %h", s, obs, exp);
            else pass_cnt++;
            if (s == g + 1) begin
                pend[m_w] = 1'b0;
                m_ptr     = !m_w;
            end
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(2) == 0) begin
                    pend[i] = 1'b1;
                    dat[i]  = 4'($urandom);
                end
            end
            req0 = pend[0]; req1 = pend[1];
            d0 = dat[0]; d1 = dat[1];
            if (s != g && s != g + 1 && pend != 2'b00) begin
                g   = s + 1;
                m_w = (pend == 2'b11) ? m_ptr : pend[1];
                m_d = dat[m_w];
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge ck);
        @(posedge ck);
    endtask

`ifdef REG_WR_ARB_LOCK_EN
    task automatic test_lock;
        logic [1:0] exp_ack;
        do_reset;
        lock0 = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        d0 = 4'h5; d1 = 4'hA;
        for (int s = 1; s <= 11; s++) begin
            @(posedge ck);
            exp_ack = (s == 2 || s == 5 || s == 8) ? 2'b01 : (s == 11) ? 2'b10 : 2'b00;
            chk_cnt++;
            if ({ack1, ack0} !== exp_ack)
                $display("FAIL lock step %0d: got ack %b expected %b", s, {ack1, ack0}, exp_ack);
            else pass_cnt++;
            if (s == 8) lock0 = 1'b0;
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge ck);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single;
        test_async_reset;
        test_contention;
        test_fairness;
        test_abort;
        test_wrap;
        test_random;
`ifdef REG_WR_ARB_LOCK_EN
        test_lock;
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
